// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction prefetch into a credit-limited queue.
// A redirect flushes the queue and silently drops responses still in flight.
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              pc_inc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW+1:0] CAP = DEPTH[CW+1:0];

    logic [31:0]       word_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count, outstanding, drop;
    logic [CW+1:0]     credits;
    logic [ADDR_W-1:0] fetch_pc, rsp_pc, last_pc;
    logic              empty, req_hs, push, pop, drop_rsp;

    // Every queued, in-flight or to-be-dropped word holds one credit
    assign credits       = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop};
    assign mem_req_valid = !rst && !redirect && credits < CAP;
    assign mem_req_addr  = fetch_pc;
    assign req_hs        = mem_req_valid && mem_req_ready;
    assign empty         = count == '0;
    assign drop_rsp      = mem_rsp_valid && drop != '0;
    assign push          = mem_rsp_valid && drop == '0 && !redirect;
    assign pop           = pc_inc && !empty && !redirect;
    assign instr_valid   = !empty;
    assign instruction   = empty ? 32'h0 : word_q[head];
    assign instr_pc      = empty ? last_pc : pc_q[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            // A response landing this cycle retires one credit whichever counter owns it
            drop        <= drop + outstanding - CW'(mem_rsp_valid);
        end else begin
            if (req_hs)
                fetch_pc <= fetch_pc + ADDR_W'(4);
            if (push) begin
                rsp_pc <= rsp_pc + ADDR_W'(4);
                tail   <= tail + PW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(req_hs) - CW'(push);
            drop        <= drop - CW'(drop_rsp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_pc <= '0;
        else if (!empty)
            last_pc <= pc_q[head];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[tail] <= mem_rsp_data;
            pc_q[tail]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a latency-programmable memory model.
module tb_fetch_unit;
    logic        clk, rst;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        pc_inc, redirect;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    int          n_chk = 0, n_pass = 0, n_req = 0;
    int          cyc = 0, lat = 1, last_due = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .pc_inc(pc_inc), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory: returns one word per cycle, in order, lat cycles after acceptance
    initial begin
        mem_rsp_valid = 0;
        mem_rsp_data  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) pend.delete();
            if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
                mem_rsp_valid = 1;
                mem_rsp_data  = mdata(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem_rsp_valid = 0;
            end
        end
    end

    // Monitor: requests feed the scoreboard, consumed instructions drain it
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb.delete();
                last_due = 0;
            end else if (redirect) begin
                sb.delete();
            end else begin
                if (pc_inc && instr_valid) begin
                    check("sb_nonempty", 64'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_pc = sb.pop_front();
                        check("instr_pc", instr_pc, exp_pc);
                        check("instr_word", instruction, mdata(exp_pc));
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    sb.push_back(mem_req_addr);
                    n_req++;
                    last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                    pend.push_back('{addr: mem_req_addr, due: last_due});
                end
            end
        end
    end

    initial begin
        logic [31:0] seen[3];
        int got;
        rst = 1; mem_req_ready = 1; pc_inc = 0; redirect = 0; redirect_pc = 0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_req", mem_req_valid, 0);
        @(negedge clk);
        rst = 0;
        n_req = 0;
        #2;
        check("first_req_valid", mem_req_valid, 1);
        check("first_req_addr", mem_req_addr, 0);

        // fill with no consumption
        repeat (12) @(negedge clk);
        #2;
        check("fill_nreq", n_req, 4);
        check("fill_noreq", mem_req_valid, 0);
        check("fill_valid", instr_valid, 1);
        check("fill_pc", instr_pc, 0);
        check("fill_word", instruction, mdata(0));

        // streaming, one per cycle without bubbles
        @(negedge clk);
        pc_inc = 1;
        repeat (20) begin
            @(negedge clk);
            #2;
            check("stream_valid", instr_valid, 1);
        end

        // redirect with responses in flight
        lat = 3;
        repeat (8) @(negedge clk);
        redirect = 1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 0;
        #2;
        check("redir_bubble", instr_valid, 0);
        for (int i = 0; i < 30 && !instr_valid; i++) begin
            @(negedge clk);
            #2;
        end
        check("redir_valid", instr_valid, 1);
        check("redir_pc", instr_pc, 32'h100);
        check("redir_word", instruction, mdata(32'h100));

        // redirect together with pc_inc on a full queue
        pc_inc = 0; lat = 1;
        repeat (15) @(negedge clk);
        #2;
        check("full_valid", instr_valid, 1);
        check("full_noreq", mem_req_valid, 0);
        @(negedge clk);
        redirect = 1; pc_inc = 1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 0; pc_inc = 0;
        #2;
        check("rp_valid", instr_valid, 0);
        check("rp_req", mem_req_valid, 1);
        check("rp_addr", mem_req_addr, 32'h200);
        for (int i = 0; i < 30 && !instr_valid; i++) begin
            @(negedge clk);
            #2;
        end
        check("rp_head_valid", instr_valid, 1);
        check("rp_head_pc", instr_pc, 32'h200);

        // back-pressure keeps the request stable
        repeat (10) @(negedge clk);
        redirect = 1; redirect_pc = 32'h300; mem_req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            redirect = 0;
            #2;
            check("bp_valid", mem_req_valid, 1);
            check("bp_addr", mem_req_addr, 32'h300);
        end
        @(negedge clk);
        mem_req_ready = 1;
        @(negedge clk);
        #2;
        check("bp_next", mem_req_addr, 32'h304);

        // asynchronous reset between edges
        pc_inc = 1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_instr", instruction, 0);
        check("arst_pc", instr_pc, 0);
        check("arst_req", mem_req_valid, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        #2;
        check("arst_restart", mem_req_valid, 1);
        check("arst_addr", mem_req_addr, 0);

        // fetch address wrap
        repeat (6) @(negedge clk);
        redirect = 1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 0;
        got = 0;
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            @(negedge clk);
            #2;
            if (instr_valid) begin
                seen[got] = instr_pc;
                got++;
            end
        end
        check("wrap_count", got, 3);
        check("wrap_pc0", seen[0], 32'hFFFF_FFF8);
        check("wrap_pc1", seen[1], 32'hFFFF_FFFC);
        check("wrap_pc2", seen[2], 32'h0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
